// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - Sequential leading/trailing-zero normaliser with shift count
//
// Purpose:
//   Normalises a word toward the MSB (dir_sel=0) or the LSB (dir_sel=1). It
//   uses a binary search that handles one stage per clock, with shift amounts
//   DATA_WIDTH/2 down to 1. It returns the normalised word and the shift
//   amount, so a downstream barrel shifter can restore the original word.
//
// Optional feature macro: SHIFT_NORMALIZER_BACK2BACK_EN
//   Defined   : in DONE, in_ready follows out_ready. A new word can be accepted
//               on the same edge as the output handshake.
//   Undefined : in_ready is high only in IDLE, so one IDLE cycle separates
//               transactions.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data and dir_sel are sampled on accept
//   in_data, dir_sel    word to normalise; 0 = toward MSB, 1 = toward LSB
//   out_valid/out_ready output handshake
//   out_data            normalised word
//   out_shift           number of bit positions shifted
//   out_zero            input word was all zeros
module shift_normalizer #(
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  dir_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SHIFT_W-1:0]    out_shift,
  output logic                  out_zero
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_work;
  logic                  r_dir;
  logic [SHIFT_W-1:0]    r_count;
  logic [SHIFT_W-1:0]    r_stage;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SHIFT_W-1:0]    r_out_shift;
  logic                  r_out_zero;

  logic [SHIFT_W:0]      w_amt;
  logic [DATA_WIDTH-1:0] w_mask_hi;
  logic [DATA_WIDTH-1:0] w_mask_lo;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_work_next;
  logic [SHIFT_W-1:0]    w_count_next;
  logic                  w_accept;

  // One search stage. Amount = 2^stage. A stage "hits" when the a bits at
  // the leading end (for the current direction) are all zero.
  always_comb begin
    w_amt          = '0;
    w_amt[r_stage] = 1'b1;
    w_mask_hi      = ~(ONES >> w_amt);
    w_mask_lo      = ~(ONES << w_amt);
    w_hit          = r_dir ? ((r_work & w_mask_lo) == '0)
                           : ((r_work & w_mask_hi) == '0);
    w_work_next    = r_work;
    w_count_next   = r_count;
    if (w_hit) begin
      w_work_next           = r_dir ? (r_work >> w_amt) : (r_work << w_amt);
      w_count_next[r_stage] = 1'b1;
    end
  end

  always_comb begin
    in_ready = (r_state == IDLE);
`ifdef SHIFT_NORMALIZER_BACK2BACK_EN
    if (r_state == DONE) in_ready = out_ready;
`endif
  end

  assign w_accept = in_valid & in_ready;

  // Under the back-to-back build, an accept in DONE implies out_ready, so
  // the accept branch also retires the pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_dir       <= 1'b0;
      r_count     <= '0;
      r_stage     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_shift <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_accept) begin
      r_work  <= in_data;
      r_dir   <= dir_sel;
      r_count <= '0;
      r_stage <= SHIFT_W'(SHIFT_W - 1);
      if (in_data == '0) begin
        r_out_data  <= '0;
        r_out_shift <= '0;
        r_out_zero  <= 1'b1;
        r_out_valid <= 1'b1;
        r_state     <= DONE;
      end else begin
        r_out_zero  <= 1'b0;
        r_out_valid <= 1'b0;
        r_state     <= SEARCH;
      end
    end else begin
      case (r_state)
        SEARCH: begin
          r_work  <= w_work_next;
          r_count <= w_count_next;
          if (r_stage == '0) begin
            r_out_data  <= w_work_next;
            r_out_shift <= w_count_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_stage <= r_stage - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_shift = r_out_shift;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - Directed self-checking bench for shift_normalizer
module tb_shift_normalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       dir_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_shift;
  logic       out_zero;

  int n_cmp = 0;
  int n_bad = 0;

  shift_normalizer #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dir_sel   (dir_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, then wait for the result and count edges from the accept
  // edge. Leaves the result pending; the caller retires it.
  task automatic start_and_wait(input string tag, input logic dir, input logic [7:0] d,
                                output int lat);
    in_valid = 1'b1;
    in_data  = d;
    dir_sel  = dir;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'hA5;
    dir_sel  = ~dir;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic dir, input logic [7:0] d,
                     input logic [7:0] e_data, input int e_shift, input logic e_zero,
                     input int e_lat);
    int lat;
    start_and_wait(tag, dir, d, lat);
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_data"}, out_data, e_data);
    chk({tag, "_shift"}, out_shift, e_shift);
    chk({tag, "_zero"}, out_zero, e_zero);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    tick();
  endtask

  initial begin
    int  lat;
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    dir_sel   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_shift", out_shift, 0);
    chk("rst_zero", out_zero, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run("l13", 1'b0, 8'h13, 8'h98, 3, 1'b0, 4);
    run("r50", 1'b1, 8'h50, 8'h05, 4, 1'b0, 4);
    run("l00", 1'b0, 8'h00, 8'h00, 0, 1'b1, 1);
    run("l80", 1'b0, 8'h80, 8'h80, 0, 1'b0, 4);
    run("l01", 1'b0, 8'h01, 8'h80, 7, 1'b0, 4);
    run("r80", 1'b1, 8'h80, 8'h01, 7, 1'b0, 4);
    run("r00", 1'b1, 8'h00, 8'h00, 0, 1'b1, 1);
    run("r0c", 1'b1, 8'h0C, 8'h03, 2, 1'b0, 4);

    // Stall in DONE while a new word is offered.
    start_and_wait("stall", 1'b0, 8'h24, lat);
    chk("stall_latency", lat, 4);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    dir_sel  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h90);
      chk("stall_shift", out_shift, 2);
      chk("stall_zero", out_zero, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
`ifdef SHIFT_NORMALIZER_BACK2BACK_EN
    #1;
    chk("b2b_in_ready", in_ready, 1);
`endif
    tick();
    out_ready = 1'b0;
`ifdef SHIFT_NORMALIZER_BACK2BACK_EN
    in_valid = 1'b0;
    chk("b2b_accepted", in_ready, 0);
    lat = 1;
`else
    chk("post_hs_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
`endif
    chk("ff_valid_early", out_valid, 0);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("ff_latency", lat, 4);
    chk("ff_data", out_data, 8'hFF);
    chk("ff_shift", out_shift, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    // Reset in the middle of a search aborts the word.
    in_valid = 1'b1;
    in_data  = 8'h03;
    dir_sel  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_shift", out_shift, 0);
    chk("abort_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);

    run("post_rst", 1'b1, 8'h40, 8'h01, 6, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
